shift_register_sequencer: RTL
=============================

# shift_register_sequencer

Controller that loads a parallel word into a serial D-flip-flop shift-register chain, one bit per clock, and then reads the chain's parallel taps back to confirm the load. It sits between a word producer, which uses a valid/ready handshake, and a WIDTH-stage shift chain, which is clocked by the same clock and gated by this block's shift enable. It supports a hold/stall input and reports completion and readback mismatch to the producer.

## Interface
- WIDTH, 4, number of stages in the shift chain; legal range 2..32.
- GAP, 1, idle cycles after each word before accepting the next; 0 is legal.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a word on in_data.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  parallel word to load.
- hold  in  1  stall; freezes shifting while high.
- sr_shift  out  1  shift enable to chain; chain advances one stage on each edge where it is 1.
- sr_din  out  1  serial data into chain stage 0.
- sr_q  in  WIDTH  parallel taps of chain; sr_q[k] is stage k, where stage 0 is nearest sr_din.
- busy  out  1  word in flight (SHIFT, CHECK or GAP).
- done  out  1  one-cycle pulse when a load completes.
- mismatch  out  1  readback differed from the loaded word; sticky until the next accept.
- word_out  out  WIDTH  last word read back from sr_q, captured in CHECK.

## Operation
- FSM states: IDLE, SHIFT, CHECK, GAP.
- **IDLE:**
  - in_ready=1.
  - On in_valid&in_ready: latch in_data into shadow register, load bit counter with WIDTH, clear mismatch, go to SHIFT.
- **SHIFT:**
  - sr_shift = ~hold; sr_din = shadow[cnt-1].
  - Bits go out MSB first, so after WIDTH shifts sr_q[k] == in_data[k].
  - Counter decrements only on cycles with sr_shift=1.
  - After the shift with cnt==1, go to CHECK.
- **CHECK:**
  - Lasts exactly one cycle; hold is ignored.
  - word_out <= sr_q; mismatch <= (sr_q != shadow); done=1.
  - Next state is GAP if GAP>0, else IDLE.
- **GAP:**
  - Counts GAP cycles, then goes to IDLE.
  - hold does not extend GAP.
- in_ready=0 in every state except IDLE, so in_valid is ignored while busy.
- hold in IDLE or GAP has no effect.
- sr_din=0 whenever sr_shift=0.
- Counter width is $clog2(WIDTH+1) bits and never wraps below 0.
- **Reset:**
  - On the rst edge, from any state including mid-SHIFT: state=IDLE, counters=0, shadow=0, word_out=0.
  - Outputs sr_shift=0, sr_din=0, done=0, busy=0, mismatch=0.
  - in_ready is 0 while rst=1 and 1 in the first cycle after release.
  - The chain contents are not cleared by this block.

## Timing
- Outputs are registered or decoded from registered state only; there is no combinational path from in_valid or hold to in_ready.
- sr_shift is decoded from state and hold; this is the only input-to-output path.
- Handshake at edge t (no hold):
  - SHIFT occupies cycles t+1..t+WIDTH.
  - CHECK, with done=1, is at t+WIDTH+1.
  - GAP is at t+WIDTH+2..t+WIDTH+1+GAP.
  - in_ready=1 again at t+WIDTH+2+GAP.
- Each cycle of hold=1 in SHIFT adds exactly one cycle to every later milestone.
- word_out and mismatch become valid in the cycle after CHECK and remain stable until the next CHECK.
- Back-to-back words are allowed when in_valid is held high: throughput is one word per WIDTH+2+GAP cycles.

## Structure
- Package shift_register_sequencer_pkg holds:
  - the state enum (IDLE, SHIFT, CHECK, GAP);
  - the function cnt_width(WIDTH) returning $clog2(WIDTH+1).
- One sub-module is natural: sequencer_down_counter, a loadable down-counter with enable and a zero flag. It is instantiated twice, once as the bit counter and once as the GAP counter.
- The bench supplies a behavioural WIDTH-stage shift chain (stage k+1 <= stage k when sr_shift=1) wired sr_din→stage 0, with sr_q fed back.

## Test plan
- Reset, then WIDTH=4, GAP=1, in_data=4'b1011 at edge t:
  - sr_din sequence 1,0,1,1 on t+1..t+4;
  - done at t+5; word_out=4'b1011, mismatch=0;
  - in_ready high at t+7.
- Same word with hold=1 for 2 cycles mid-SHIFT → exactly 4 shifts, done at t+7, word_out=4'b1011.
- Bench forces sr_q[2] stuck at 0, load 4'b0100 → done pulses, mismatch=1, word_out=4'b0000. The next accept clears mismatch.
- GAP=0, in_valid held high with words 4'hA then 4'h5 → second accept exactly WIDTH+2=6 cycles after the first; both read back correctly.
- rst asserted during the second SHIFT cycle:
  - next cycle all outputs 0, no done pulse, in_ready=1 after release;
  - a fresh load of 4'hF gives word_out=4'hF.
- in_valid pulsed during SHIFT/GAP → ignored: no extra accept, counters undisturbed.

Source files
------------

// File: rtl/shift_register_sequencer_pkg.sv
// Shared types and helpers for the shift-register load/readback sequencer.
package shift_register_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK,
        S_GAP
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sequencer_down_counter.sv
// Loadable down-counter with enable; saturates at zero and flags it.
module sequencer_down_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/shift_register_sequencer.sv
// Serialises a parallel word MSB-first into an external shift chain, then
// reads the chain taps back and reports completion and readback mismatch.
module shift_register_sequencer
    import shift_register_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             hold,
    output logic             sr_shift,
    output logic             sr_din,
    input  logic [WIDTH-1:0] sr_q,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [WIDTH-1:0] word_out
);

    localparam int CW = cnt_width(WIDTH);
    localparam int GW = (GAP > 0) ? cnt_width(GAP) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] word_out_q, word_out_d;
    logic             mismatch_q, mismatch_d;

    logic [CW-1:0] bit_cnt;
    logic          bit_zero;
    logic [GW-1:0] gap_cnt;
    logic          gap_zero;
    logic          accept;
    logic          shift_en;
    logic          din_bit;

    // in_ready depends only on registered state and rst, never on in_valid/hold.
    assign in_ready = (state_q == S_IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign shift_en = (state_q == S_SHIFT) && !hold;

    sequencer_down_counter #(.W(CW)) u_bit_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (CW'(WIDTH)),
        .en       (shift_en),
        .cnt      (bit_cnt),
        .zero     (bit_zero)
    );

    sequencer_down_counter #(.W(GW)) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == S_CHECK),
        .load_val (GW'(GAP)),
        .en       (state_q == S_GAP),
        .cnt      (gap_cnt),
        .zero     (gap_zero)
    );

    // Bit cnt-1 of the shadow word goes out next, so the MSB leaves first.
    always_comb begin
        din_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bit_cnt == CW'(i + 1)) begin
                din_bit = shadow_q[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        word_out_d = word_out_q;
        mismatch_d = mismatch_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shadow_d   = in_data;
                    mismatch_d = 1'b0;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (shift_en && (bit_cnt == CW'(1))) begin
                    state_d = S_CHECK;
                end else if (bit_zero) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                word_out_d = sr_q;
                mismatch_d = (sr_q != shadow_q);
                state_d    = (GAP > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (gap_zero || (gap_cnt == GW'(1))) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shadow_q   <= '0;
            word_out_q <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            word_out_q <= word_out_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign sr_shift = shift_en;
    assign sr_din   = shift_en && din_bit;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_CHECK);
    assign mismatch = mismatch_q;
    assign word_out = word_out_q;

endmodule
